// File: rtl/clock_speed_controller.sv
// Push-button speed sequencer for the visualizer clock divider.
// Debounces the button, steps the divide ratio, applies it at full-period ends.
`timescale 1ns/1ps
module clock_speed_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_SPEEDS      = 4,
  parameter int BASE_HALF       = 2,
  parameter int CNT_W           = 16,
  localparam int LW = $clog2(NUM_SPEEDS),
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          speedButton,
  output logic          newClock,
  output logic          tick,
  output logic [LW-1:0] speedLevel,
  output logic          switching
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic             sync1;
  logic             sync2;
  logic             db;
  logic             press;
  logic [DW-1:0]    dcnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hm1;
  logic             boundary;
  logic [0:0]       state;
  logic [LW-1:0]    pending;

  assign hm1       = (CNT_W'(BASE_HALF) << speedLevel) - CNT_W'(1);
  assign boundary  = (count == hm1);
  assign switching = (state == PENDING);

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= speedButton;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a level after it has differed long enough
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db    <= 1'b0;
      dcnt  <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != db) begin
        if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          db    <= sync2;
          dcnt  <= '0;
          press <= sync2;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  // Divider plus level sequencer; level swaps only as newClock falls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      newClock   <= 1'b0;
      tick       <= 1'b0;
      speedLevel <= '0;
      pending    <= '0;
      state      <= RUN;
    end else begin
      if (boundary) begin
        count    <= '0;
        newClock <= ~newClock;
        tick     <= ~newClock;
      end else begin
        count <= count + CNT_W'(1);
        tick  <= 1'b0;
      end
      unique case (state)
        RUN: begin
          if (press) begin
            pending <= speedLevel + LW'(1);
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (boundary && newClock) begin
            speedLevel <= pending;
            state      <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_speed_controller.sv
// Randomised bench for clock_speed_controller against a phase-based model.
// Directed scenarios pin the model with literal latencies and periods.
`timescale 1ns/1ps
module tb_clock_speed_controller;

  localparam int DC = 4;
  localparam int NS = 4;
  localparam int BH = 2;

  logic       clock;
  logic       reset;
  logic       speedButton;
  logic       newClock;
  logic       tick;
  logic [1:0] speedLevel;
  logic       switching;

  int checks;
  int errors;
  bit go;

  clock_speed_controller #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_SPEEDS(NS),
    .BASE_HALF(BH),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .speedButton(speedButton),
    .newClock(newClock),
    .tick(tick),
    .speedLevel(speedLevel),
    .switching(switching)
  );

  initial clock = 1'b0;
  always #1 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph is position within the current full period (0..2H-1)
  int  m_ph, m_lvl, m_pl;
  bit  m_pend, m_db, m_p1, m_p2, m_press;
  bit  hist[$];
  int  mh;
  bit  ms, mdiff, mnew, mbnd;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_lvl = 0; m_pl = 0;
      m_pend = 0; m_db = 0; m_p1 = 0; m_p2 = 0; m_press = 0;
      hist.delete();
    end else begin
      ms = m_p2; m_p2 = m_p1; m_p1 = speedButton;
      hist.push_back(ms);
      if (hist.size() > DC) void'(hist.pop_front());
      mdiff = 1;
      foreach (hist[i]) if (hist[i] == m_db) mdiff = 0;
      mnew = 0;
      if (hist.size() == DC && mdiff) begin
        m_db = ~m_db;
        hist.delete();
        mnew = m_db;
      end
      mh = BH << m_lvl;
      mbnd = (m_ph == 2 * mh - 1);
      if (m_pend && mbnd) begin
        m_lvl = m_pl; m_pend = 0; m_ph = 0;
      end else begin
        if (!m_pend && m_press) begin
          m_pend = 1;
          m_pl = (m_lvl + 1) % NS;
        end
        m_ph = (m_ph + 1) % (2 * mh);
      end
      m_press = mnew;
    end
  end

  // Per-cycle comparison plus minimum phase length
  int  run_len;
  bit  last_nc;
  always @(negedge clock) begin
    if (go) begin
      chk("newClock", newClock, int'(m_ph >= (BH << m_lvl)));
      chk("tick", tick, int'(m_ph == (BH << m_lvl)));
      chk("speedLevel", speedLevel, m_lvl);
      chk("switching", switching, int'(m_pend));
      if (reset) begin
        run_len = 2;
      end else if (newClock != last_nc) begin
        chk("min_phase", int'(run_len >= 2), 1);
        run_len = 1;
      end else begin
        run_len++;
      end
      last_nc = newClock;
    end
  end

  task automatic step();
    @(posedge clock);
    #0.5;
  endtask

  task automatic measure(output int hi, output int lo);
    int n;
    hi = 0; lo = 0; n = 0;
    while (newClock && n < 300) begin step(); n++; end
    while (!newClock && n < 300) begin step(); n++; end
    while (newClock && n < 300) begin hi++; step(); n++; end
    while (!newClock && n < 300) begin lo++; step(); n++; end
    chk("measure_timeout", int'(n < 300), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (switching && n < 300) begin step(); n++; end
    chk("idle_switching", switching, 0);
  endtask

  task automatic press_btn(input int hold);
    speedButton = 1'b1;
    repeat (hold) step();
    speedButton = 1'b0;
    repeat (8) step();
  endtask

  task automatic press_expect(input string nm, input int lvl, input int h);
    int hi, lo;
    press_btn(10);
    wait_idle();
    chk({nm, "_level"}, speedLevel, lvl);
    measure(hi, lo);
    chk({nm, "_high"}, hi, h);
    chk({nm, "_low"}, lo, h);
  endtask

  task automatic pulse_reset_check(input string nm);
    reset = 1'b1;
    #0.1;
    chk({nm, "_nc"}, newClock, 0);
    chk({nm, "_tick"}, tick, 0);
    chk({nm, "_lvl"}, speedLevel, 0);
    chk({nm, "_sw"}, switching, 0);
    #0.4;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    int hi, lo, n, lat, ticks;
    checks = 0; errors = 0; go = 0;
    run_len = 2; last_nc = 0;
    reset = 1'b1;
    speedButton = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    go = 1;

    // 1: reset mid-run, then level-0 timing
    repeat (13) step();
    n = 0;
    while (!newClock && n < 20) begin step(); n++; end
    chk("pre_reset_nc_high", newClock, 1);
    pulse_reset_check("rst1");
    measure(hi, lo);
    chk("l0_high", hi, 2);
    chk("l0_low", lo, 2);
    ticks = 0;
    repeat (40) begin
      step();
      if (tick) ticks++;
    end
    chk("l0_ticks_in_40", ticks, 10);

    // 2: bounce never reaches the debounce threshold
    repeat (30) begin
      speedButton = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      speedButton = 1'b0;
      step();
    end
    repeat (10) step();
    chk("bounce_level", speedLevel, 0);
    chk("bounce_switching", switching, 0);

    // 3: clean press latency and first switch
    speedButton = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (switching) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", lat, 7);
    repeat (3) step();
    speedButton = 1'b0;
    repeat (8) step();
    wait_idle();
    chk("p1_level", speedLevel, 1);
    measure(hi, lo);
    chk("p1_high", hi, 4);
    chk("p1_low", lo, 4);

    // 4: remaining presses wrap back to fastest
    press_expect("p2", 2, 8);
    press_expect("p3", 3, 16);
    press_expect("p4", 0, 2);

    // 5: second press during pending is dropped
    press_expect("q1", 1, 4);
    press_expect("q2", 2, 8);
    press_expect("q3", 3, 16);
    n = 0;
    while (!newClock && n < 100) begin step(); n++; end
    while (newClock && n < 100) begin step(); n++; end
    speedButton = 1'b1; repeat (4) step();
    speedButton = 1'b0; repeat (4) step();
    speedButton = 1'b1; repeat (6) step();
    chk("dbl_mid_switching", switching, 1);
    speedButton = 1'b0;
    wait_idle();
    repeat (40) step();
    chk("dbl_level", speedLevel, 0);
    chk("dbl_switching", switching, 0);

    // 6: reset while pending at level 2
    press_expect("r1", 1, 4);
    press_expect("r2", 2, 8);
    speedButton = 1'b1;
    n = 0;
    while (!switching && n < 40) begin step(); n++; end
    chk("r_pending", switching, 1);
    pulse_reset_check("rst2");
    speedButton = 1'b0;
    step();
    chk("r_level", speedLevel, 0);
    chk("r_switching", switching, 0);
    measure(hi, lo);
    chk("r_high", hi, 2);
    chk("r_low", lo, 2);

    // Random button activity with occasional resets
    for (int k = 0; k < 150; k++) begin
      speedButton = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) step();
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b0;
      end
    end
    speedButton = 1'b0;
    repeat (20) step();

    go = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
